// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for the RV32I core.
// Owns the PC, issues one word read at a time to instruction memory, holds the
// returned instruction for decode, and selects the next PC on retirement.
// Optional feature: define IFU_PERF_EN to build the retired/stall counters;
// without it both counter outputs are tied to zero and no counter flops exist.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,  // bits [1:0] must be zero
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013   // addi x0,x0,0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   // Instruction memory
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   // Decode / datapath
   output logic [31:0] instr_o,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   input  logic        br_sel_i,
   input  logic [31:0] alu_data_i,
   output logic [31:0] pc_o,
   output logic [31:0] pc_four_o,
   // Performance counters
   output logic [31:0] retired_o,
   output logic [31:0] stall_o
);

   typedef enum logic [1:0] {
      StRst   = 2'd0,
      StFetch = 2'd1,
      StHold  = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_plus4;
   logic [31:0] br_target;
   logic        retire;
   logic        fetch_wait;

   // Target bits [1:0] are dropped on purpose (JALR bit-0 clear, word alignment).
   logic        unused_alu_lsb;
   assign unused_alu_lsb = ^alu_data_i[1:0];

   assign pc_plus4  = pc_q + 32'd4;
   assign br_target = {alu_data_i[31:2], 2'b00};

   // Next-state and datapath decisions; rvalid outside FETCH is ignored.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      retire     = 1'b0;
      fetch_wait = 1'b0;
      unique case (state_q)
         StRst: begin
            state_d = StFetch;
         end
         StFetch: begin
            if (imem_rvalid_i) begin
               instr_d = imem_rdata_i;
               state_d = StHold;
            end else begin
               fetch_wait = 1'b1;
            end
         end
         StHold: begin
            if (instr_ready_i) begin
               retire  = 1'b1;
               pc_d    = br_sel_i ? br_target : pc_plus4;
               instr_d = NOP_INSTR;
               state_d = StFetch;
            end
         end
         default: begin
            state_d = StRst;
         end
      endcase
   end

   // State, PC and held-instruction registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StRst;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   // Outputs decode directly from the registered state, so an async reset
   // drops the request without waiting for a clock edge.
   assign imem_req_o    = (state_q == StFetch);
   assign imem_addr_o   = pc_q;
   assign instr_valid_o = (state_q == StHold);
   assign instr_o       = instr_q;
   assign pc_o          = pc_q;
   assign pc_four_o     = pc_plus4;

`ifdef IFU_PERF_EN
   logic [31:0] retired_q;
   logic [31:0] stall_q;

   // Retired-instruction and fetch-wait counters, both wrap modulo 2^32.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         retired_q <= 32'd0;
         stall_q   <= 32'd0;
      end else begin
         if (retire) begin
            retired_q <= retired_q + 32'd1;
         end
         if (fetch_wait) begin
            stall_q <= stall_q + 32'd1;
         end
      end
   end

   assign retired_o = retired_q;
   assign stall_o   = stall_q;
`else
   logic unused_perf;
   assign unused_perf = retire ^ fetch_wait;

   assign retired_o = 32'd0;
   assign stall_o   = 32'd0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: the driver plays instruction memory
// and retirement from a directed table, pushing expected fetch addresses and
// held instructions into queues; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rst_nw = 1'b0;
   always #5 clk = ~clk;

   // Main DUT (RESET_PC = 0)
   logic        imem_req_o, instr_valid_o;
   logic [31:0] imem_addr_o, instr_o, pc_o, pc_four_o, retired_o, stall_o;
   logic        imem_rvalid = 1'b0, instr_ready = 1'b0, br_sel = 1'b0;
   logic [31:0] imem_rdata = '0, alu_data = '0;

   instr_fetch_unit dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_rvalid_i (imem_rvalid),
      .imem_rdata_i  (imem_rdata),
      .instr_o       (instr_o),
      .instr_valid_o (instr_valid_o),
      .instr_ready_i (instr_ready),
      .br_sel_i      (br_sel),
      .alu_data_i    (alu_data),
      .pc_o          (pc_o),
      .pc_four_o     (pc_four_o),
      .retired_o     (retired_o),
      .stall_o       (stall_o)
   );

   // Wrap DUT (RESET_PC = 32'hFFFF_FFFC)
   logic        w_req, w_valid;
   logic [31:0] w_addr, w_instr, w_pc, w_pc_four, w_retired, w_stall;
   logic        w_rvalid = 1'b0, w_ready = 1'b0;
   logic [31:0] w_rdata = '0;

   instr_fetch_unit #(
      .RESET_PC (32'hFFFF_FFFC)
   ) dut_w (
      .clk_i         (clk),
      .rst_ni        (rst_nw),
      .imem_req_o    (w_req),
      .imem_addr_o   (w_addr),
      .imem_rvalid_i (w_rvalid),
      .imem_rdata_i  (w_rdata),
      .instr_o       (w_instr),
      .instr_valid_o (w_valid),
      .instr_ready_i (w_ready),
      .br_sel_i      (1'b0),
      .alu_data_i    (32'h0),
      .pc_o          (w_pc),
      .pc_four_o     (w_pc_four),
      .retired_o     (w_retired),
      .stall_o       (w_stall)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] addr_q[$];
   logic [63:0] instr_q[$];

   // Directed table: latency, data, hold cycles, branch, target, expected PC/next PC
   int          e_lat [6] = '{1, 1, 4, 2, 1, 1};
   int          e_hold[6] = '{0, 0, 5, 0, 0, 0};
   logic        e_br  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
   logic [31:0] e_data[6] = '{32'h0050_0093, 32'h0000_0113, 32'h0000_0193,
                              32'h0040_0213, 32'h0000_0293, 32'h0000_0313};
   logic [31:0] e_alu [6] = '{32'h0, 32'h0000_0103, 32'h0, 32'h0000_0041, 32'h0, 32'h0};
   logic [31:0] e_pc  [6] = '{32'h0, 32'h4, 32'h100, 32'h104, 32'h0, 32'h4};
   logic [31:0] e_next[6] = '{32'h4, 32'h100, 32'h104, 32'h40, 32'h4, 32'h8};

   logic [31:0] ret_exp = 0;
   logic [31:0] stall_exp = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_counters();
`ifdef IFU_PERF_EN
      chk("retired_cnt", retired_o, ret_exp);
      chk("stall_cnt", stall_o, stall_exp);
`else
      chk("retired_tied", retired_o, 32'd0);
      chk("stall_tied", stall_o, 32'd0);
`endif
   endtask

   // Monitor: compares on request rise, on instruction presentation and while held.
   logic        req_prev = 1'b0, valid_prev = 1'b0;
   logic [31:0] cur_addr = '0, held_pc = '0, held_instr = '0;
   logic [63:0] exp_ent;

   always @(negedge clk) begin
      if (!rst_n) begin
         req_prev   = 1'b0;
         valid_prev = 1'b0;
      end else begin
         chk("req_valid_exclusive", {31'd0, imem_req_o & instr_valid_o}, 32'd0);
         if (imem_req_o && !req_prev) begin
            if (addr_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL fetch_addr actual=%h required=<no request expected>", imem_addr_o);
            end else begin
               cur_addr = addr_q.pop_front();
               chk("fetch_addr", imem_addr_o, cur_addr);
            end
         end else if (imem_req_o) begin
            chk("fetch_addr_stable", imem_addr_o, cur_addr);
         end
         if (instr_valid_o && !valid_prev) begin
            if (instr_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL instr actual=%h required=<no instruction expected>", instr_o);
            end else begin
               exp_ent    = instr_q.pop_front();
               held_pc    = exp_ent[63:32];
               held_instr = exp_ent[31:0];
               chk("instr", instr_o, held_instr);
               chk("instr_pc", pc_o, held_pc);
               chk("pc_four", pc_four_o, held_pc + 32'd4);
            end
         end else if (instr_valid_o) begin
            chk("instr_hold", instr_o, held_instr);
            chk("pc_hold", pc_o, held_pc);
         end
         req_prev   = imem_req_o;
         valid_prev = instr_valid_o;
      end
   end

   task automatic run_entry(input int i);
      int cnt = 0;
      while (!imem_req_o && cnt < 50) begin
         @(posedge clk); #1;
         cnt++;
      end
      if (!imem_req_o) begin
         n_checks++;
         n_errors++;
         $display("FAIL req_timeout actual=0 required=1 entry=%0d", i);
         return;
      end
      repeat (e_lat[i] - 1) begin
         @(posedge clk); #1;
      end
      imem_rvalid = 1'b1;
      imem_rdata  = e_data[i];
      instr_q.push_back({e_pc[i], e_data[i]});
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      stall_exp   = stall_exp + 32'(e_lat[i] - 1);
      // Stray read data while holding must be ignored.
      if (e_hold[i] > 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = 32'hFFFF_FFFF;
      end
      repeat (e_hold[i]) begin
         @(posedge clk); #1;
      end
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      instr_ready = 1'b1;
      br_sel      = e_br[i];
      alu_data    = e_alu[i];
      addr_q.push_back(e_next[i]);
      @(posedge clk); #1;
      instr_ready = 1'b0;
      br_sel      = 1'b0;
      alu_data    = '0;
      ret_exp     = ret_exp + 32'd1;
      chk_counters();
   endtask

   initial begin
      int cnt;
      addr_q.push_back(32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc", pc_o, 32'h0);
      chk("rst_pc_four", pc_four_o, 32'h4);
      chk("rst_instr", instr_o, NOP);
      chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
      chk("rst_req", {31'd0, imem_req_o}, 32'd0);
      chk("rst_addr", imem_addr_o, 32'h0);
      chk("rst_retired", retired_o, 32'd0);
      chk("rst_stall", stall_o, 32'd0);
      chk("rst_w_pc_four", w_pc_four, 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 4; i++) run_entry(i);

      // Now fetching at 0x40; assert reset between clock edges.
      @(posedge clk); #1;
      chk("pre_reset_req", {31'd0, imem_req_o}, 32'd1);
      chk("pre_reset_addr", imem_addr_o, 32'h40);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_req_drop", {31'd0, imem_req_o}, 32'd0);
      chk("async_valid", {31'd0, instr_valid_o}, 32'd0);
      chk("async_pc", pc_o, 32'h0);
      chk("async_instr", instr_o, NOP);
      chk("async_retired", retired_o, 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      chk("reset_stray_valid", {31'd0, instr_valid_o}, 32'd0);
      addr_q.push_back(32'h0);
      ret_exp   = 0;
      stall_exp = 0;
      rst_n     = 1'b1;

      for (int i = 4; i < 6; i++) run_entry(i);
      repeat (3) @(posedge clk);
      #1;
      chk("addr_q_drained", addr_q.size(), 32'd0);
      chk("instr_q_drained", instr_q.size(), 32'd0);

      // PC wrap at the top of the address space.
      rst_nw = 1'b1;
      cnt = 0;
      while (!w_req && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("wrap_req", {31'd0, w_req}, 32'd1);
      chk("wrap_addr", w_addr, 32'hFFFF_FFFC);
      w_rvalid = 1'b1;
      w_rdata  = 32'h0000_0013;
      @(posedge clk); #1;
      w_rvalid = 1'b0;
      chk("wrap_valid", {31'd0, w_valid}, 32'd1);
      chk("wrap_pc_hold", w_pc, 32'hFFFF_FFFC);
      chk("wrap_pc_four_hold", w_pc_four, 32'h0);
      w_ready = 1'b1;
      @(posedge clk); #1;
      w_ready = 1'b0;
      chk("wrap_pc", w_pc, 32'h0);
      chk("wrap_pc_four", w_pc_four, 32'h4);
      chk("wrap_refetch_req", {31'd0, w_req}, 32'd1);
      chk("wrap_refetch_addr", w_addr, 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
